// File: rtl/tile_exerciser_pkg.sv
// tile_exerciser_pkg: shared widths, tap masks, FSM states and step functions for the tile exerciser.
package tile_exerciser_pkg;
    localparam int STIM_W = 8;
    localparam int SIG_W  = 16;
    localparam int CNT_W  = 16;
    localparam logic [STIM_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [SIG_W-1:0]  MISR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [STIM_W-1:0] lfsr_next(input logic [STIM_W-1:0] s);
        return {s[STIM_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] g, input logic [STIM_W-1:0] d);
        return {g[SIG_W-2:0], ^(g & MISR_TAPS)} ^ {{(SIG_W-STIM_W){1'b0}}, d};
    endfunction
endpackage

// File: rtl/tile_exerciser_misr.sv
// tile_exerciser_misr: 16-bit multiple-input signature register compressing tile responses.
module tile_exerciser_misr
    import tile_exerciser_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic [SIG_W-1:0]  seed,
    input  logic              enable,
    input  logic [STIM_W-1:0] data,
    output logic [SIG_W-1:0]  signature
);
    always_ff @(posedge clk) begin
        if (load)
            signature <= seed;
        else if (enable)
            signature <= misr_next(signature, data);
    end
endmodule

// File: rtl/tile_exerciser.sv
// tile_exerciser: steps stimulus onto a microtile, settles, and folds responses into a MISR.
// Build option TILE_EXERCISER_SWEEP_EN swaps the LFSR stimulus for an 8-bit up-counter.
module tile_exerciser
    import tile_exerciser_pkg::*;
#(
    parameter int                SETTLE_CYCLES = 2,
    parameter logic [STIM_W-1:0] LFSR_SEED     = 8'h01,
    parameter logic [SIG_W-1:0]  SIG_SEED      = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vectors,
    output logic [STIM_W-1:0] stim_out,
    input  logic [STIM_W-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature
);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t            state, state_n;
    logic              accept, step;
    logic [STIM_W-1:0] stim, stim_next;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        settle;

`ifdef TILE_EXERCISER_SWEEP_EN
    localparam logic [STIM_W-1:0] STIM_SEED = '0;
    assign stim_next = stim + 1'b1;
`else
    // An all-zero LFSR would lock up, so a zero seed falls back to 01.
    localparam logic [STIM_W-1:0] STIM_SEED = (LFSR_SEED == '0) ? 8'h01 : LFSR_SEED;
    assign stim_next = lfsr_next(stim);
`endif

    always_comb begin
        accept  = start && state != RUN;
        step    = state == RUN && settle == '0;
        state_n = accept ? ((num_vectors == '0) ? DONE : RUN)
                : (step && cnt == CNT_W'(1)) ? DONE : state;
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stim   <= '0;
            cnt    <= '0;
            settle <= '0;
        end else if (accept) begin
            stim   <= STIM_SEED;
            cnt    <= num_vectors;
            settle <= SETTLE_LAST;
        end else if (step) begin
            stim   <= stim_next;
            cnt    <= cnt - 1'b1;
            settle <= SETTLE_LAST;
        end else if (state == RUN) begin
            settle <= settle - 1'b1;
        end
    end

    tile_exerciser_misr u_misr (
        .clk       (clk),
        .load      (rst || accept),
        .seed      (SIG_SEED),
        .enable    (step),
        .data      (resp_in),
        .signature (signature)
    );

    assign busy     = state == RUN;
    assign done     = state == DONE;
    assign stim_out = busy ? stim : '0;
endmodule

// File: tb/tb_tile_exerciser.sv
// tb_tile_exerciser: table-driven runs with a signature scoreboard plus reset/abort/hold sequences.
module tb_tile_exerciser;
`ifdef TILE_EXERCISER_SWEEP_EN
    localparam int S = 1;
`else
    localparam int S = 2;
`endif

    typedef struct {
        int          n;
        logic [7:0]  a;
        logic [7:0]  x;
        logic [15:0] sig;
        int          poke;
    } vec_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [15:0] num_vectors = 0;
    logic [7:0]  stim_out, resp_in;
    logic        busy, done;
    logic [15:0] signature;
    logic [7:0]  amask = 0, xmask = 0;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb[$];
    vec_t        tbl[$];

    // The "tile": response is a masked/inverted copy of the stimulus.
    assign resp_in = (stim_out & amask) ^ xmask;

    always #5 clk = ~clk;

    tile_exerciser #(.SETTLE_CYCLES(S), .LFSR_SEED(8'h01), .SIG_SEED(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .stim_out(stim_out), .resp_in(resp_in), .busy(busy), .done(done),
        .signature(signature)
    );

    function automatic logic [7:0] m_lfsr(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] stim_at(input int k);
        logic [7:0] s;
`ifdef TILE_EXERCISER_SWEEP_EN
        s = 8'(k);
`else
        s = 8'h01;
        for (int i = 0; i < k; i++) s = m_lfsr(s);
`endif
        return s;
    endfunction

    function automatic logic [15:0] m_misr(input logic [15:0] g, input logic [7:0] d);
        return {g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10]} ^ {8'h00, d};
    endfunction

    function automatic logic [15:0] model_sig(input int n, input logic [7:0] a, input logic [7:0] x);
        logic [15:0] g = 16'hFFFF;
        for (int k = 0; k < n; k++) g = m_misr(g, (stim_at(k) & a) ^ x);
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the block not running; returns at the negedge where done first reads high.
    task automatic run(input vec_t v);
        int edges = 0, stim_bad = 0, busy_bad = 0;
        logic [15:0] exp_sig;
        amask = v.a;
        xmask = v.x;
        num_vectors = 16'(v.n);
        start = 1;
        sb.push_back(v.sig);
        @(negedge clk);
        start = 0;
        while (done !== 1'b1 && edges <= v.n * S + 4) begin
            if (stim_out !== stim_at(edges / S)) begin
                if (stim_bad == 0) $display("FAIL stim n=%0d edge %0d: got %0h expected %0h", v.n, edges, stim_out, stim_at(edges / S));
                stim_bad++;
            end
            if (busy !== 1'b1) busy_bad++;
            start = (edges == v.poke);
            num_vectors = (edges == v.poke) ? 16'd3 : 16'(v.n);
            @(negedge clk);
            edges++;
        end
        start = 0;
        check($sformatf("latency n=%0d", v.n), edges, v.n * S);
        check($sformatf("stim_seq n=%0d", v.n), stim_bad, 0);
        check($sformatf("busy_run n=%0d", v.n), busy_bad, 0);
        check($sformatf("idle_outs n=%0d", v.n), {busy, stim_out}, 9'h000);
        exp_sig = sb.pop_front();
        check($sformatf("signature n=%0d", v.n), signature, exp_sig);
    endtask

    initial begin
        tbl.push_back('{n: 3,  a: 8'h00, x: 8'h00, sig: 16'hFFF8, poke: -1});
        tbl.push_back('{n: 1,  a: 8'h00, x: 8'hFF, sig: 16'hFF01, poke: -1});
        tbl.push_back('{n: 2,  a: 8'h00, x: 8'h00, sig: 16'hFFFC, poke: -1});
        tbl.push_back('{n: 0,  a: 8'h00, x: 8'h00, sig: 16'hFFFF, poke: -1});
        tbl.push_back('{n: 1,  a: 8'h00, x: 8'hFF, sig: 16'hFF01, poke: -1});
        tbl.push_back('{n: 10, a: 8'hFF, x: 8'hFF, sig: model_sig(10, 8'hFF, 8'hFF), poke: 3});
        tbl.push_back('{n: 7,  a: 8'hFF, x: 8'h00, sig: model_sig(7, 8'hFF, 8'h00), poke: -1});
        tbl.push_back('{n: 40, a: 8'h0F, x: 8'hA5, sig: model_sig(40, 8'h0F, 8'hA5), poke: -1});
`ifdef TILE_EXERCISER_SWEEP_EN
        tbl.push_back('{n: 257, a: 8'hFF, x: 8'hFF, sig: model_sig(257, 8'hFF, 8'hFF), poke: -1});
`endif

        rst = 1;
        repeat (2) @(negedge clk);
        check("reset_stim", stim_out, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_sig", signature, 16'hFFFF);
        rst = 0;
        @(negedge clk);

        // Back-to-back runs: each new start lands on the cycle done first reads high.
        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

        @(negedge clk);
        check("done_hold", done, 1'b1);
        check("sig_hold", signature, tbl[tbl.size() - 1].sig);

        // Abort a 10-vector run once vector 4 is on the tile.
        amask = 8'hFF;
        xmask = 8'h00;
        num_vectors = 16'd10;
        start = 1;
        @(negedge clk);
        start = 0;
        check("abort_done_cleared", done, 1'b0);
        repeat (4 * S) @(negedge clk);
        check("abort_vec4", stim_out, stim_at(4));
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort_stim", stim_out, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sig", signature, 16'hFFFF);

        run('{n: 5, a: 8'h3C, x: 8'h81, sig: model_sig(5, 8'h3C, 8'h81), poke: -1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
